// File: rtl/rect_fetch.sv
// rect_fetch: streams the CPU-built rectangle table into renderer shadow
// registers at vblank, then releases the CPU. Option: RECT_FETCH_SKIP_CNT_EN.
module rect_fetch #(
   parameter int DATA_WIDTH = 13,
   parameter logic [DATA_WIDTH-1:0] RECT_BASE = 13'h1000,
   parameter int RECT_COUNT = 64,
   parameter int WORDS_PER_RECT = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vblank_start,
   input  logic                  cpu_wait,
   output logic                  mem_rd_en,
   output logic [DATA_WIDTH-1:0] mem_rd_addr,
   input  logic [15:0]           mem_rd_data,
   output logic                  rect_we,
   output logic [7:0]            rect_idx,
   output logic [2:0]            rect_field,
   output logic [15:0]           rect_data,
   output logic                  resume,
   output logic                  busy
`ifdef RECT_FETCH_SKIP_CNT_EN
   ,
   output logic [15:0]           skip_count
`endif
);

   localparam int TOTAL = RECT_COUNT * WORDS_PER_RECT;
   localparam logic [11:0] LAST_WORD = 12'(TOTAL - 1);
   localparam logic [2:0] LAST_FIELD = 3'(WORDS_PER_RECT - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      RESUME
   } state_t;

   state_t state;
   state_t state_next;

   logic [11:0]           word_cnt;
   logic [DATA_WIDTH-1:0] addr_cnt;
   logic [7:0]            idx_cnt;
   logic [2:0]            field_cnt;
   logic                  start;
   logic                  issue;

   assign start = (state == IDLE) && vblank_start && cpu_wait;
   assign issue = (state == READ);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      mem_rd_en  = 1'b0;
      busy       = 1'b0;
      resume     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = READ;
            end
         end
         READ: begin
            mem_rd_en = 1'b1;
            busy      = 1'b1;
            if (word_cnt == LAST_WORD) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            busy       = 1'b1;
            state_next = RESUME;
         end
         RESUME: begin
            // a CPU that already left WAIT must not see a stray release
            resume     = cpu_wait;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign mem_rd_addr = mem_rd_en ? addr_cnt : '0;

   // address runs as its own counter so base+i wraps for free
   always_ff @(posedge clk) begin
      if (reset) begin
         word_cnt  <= '0;
         addr_cnt  <= '0;
         idx_cnt   <= '0;
         field_cnt <= '0;
      end else if (start) begin
         word_cnt  <= '0;
         addr_cnt  <= RECT_BASE;
         idx_cnt   <= '0;
         field_cnt <= '0;
      end else if (issue) begin
         word_cnt <= word_cnt + 12'd1;
         addr_cnt <= addr_cnt + DATA_WIDTH'(1);
         if (field_cnt == LAST_FIELD) begin
            field_cnt <= '0;
            idx_cnt   <= idx_cnt + 8'd1;
         end else begin
            field_cnt <= field_cnt + 3'd1;
         end
      end
   end

   // write side lags issue by one cycle to meet the RAM read latency
   always_ff @(posedge clk) begin
      if (reset) begin
         rect_we    <= 1'b0;
         rect_idx   <= '0;
         rect_field <= '0;
      end else begin
         rect_we    <= issue;
         rect_idx   <= issue ? idx_cnt : '0;
         rect_field <= issue ? field_cnt : '0;
      end
   end

   assign rect_data = rect_we ? mem_rd_data : '0;

`ifdef RECT_FETCH_SKIP_CNT_EN
   logic skip_evt;

   assign skip_evt = ((state == IDLE) && vblank_start && !cpu_wait) ||
                     ((state == RESUME) && !cpu_wait);

   always_ff @(posedge clk) begin
      if (reset) begin
         skip_count <= '0;
      end else if (skip_evt && (skip_count != 16'hFFFF)) begin
         skip_count <= skip_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rect_fetch.sv
// Directed bench for rect_fetch: two instances, a small fetch at 0x100
// and a one-rectangle fetch that wraps the address space.
module tb_rect_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vblank_start = 1'b0;
   logic        cpu_wait = 1'b0;

   logic        a_en, b_en;
   logic [12:0] a_addr, b_addr;
   logic [15:0] a_rdata = '0;
   logic [15:0] b_rdata = '0;
   logic        a_we, b_we;
   logic [7:0]  a_idx, b_idx;
   logic [2:0]  a_fld, b_fld;
   logic [15:0] a_data, b_data;
   logic        a_res, b_res;
   logic        a_busy, b_busy;
`ifdef RECT_FETCH_SKIP_CNT_EN
   logic [15:0] a_skip, b_skip;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rect_fetch #(
      .DATA_WIDTH(13),
      .RECT_BASE(13'h0100),
      .RECT_COUNT(2),
      .WORDS_PER_RECT(5)
   ) dut_a (
      .clk(clk),
      .reset(reset),
      .vblank_start(vblank_start),
      .cpu_wait(cpu_wait),
      .mem_rd_en(a_en),
      .mem_rd_addr(a_addr),
      .mem_rd_data(a_rdata),
      .rect_we(a_we),
      .rect_idx(a_idx),
      .rect_field(a_fld),
      .rect_data(a_data),
      .resume(a_res),
      .busy(a_busy)
`ifdef RECT_FETCH_SKIP_CNT_EN
      ,
      .skip_count(a_skip)
`endif
   );

   rect_fetch #(
      .DATA_WIDTH(13),
      .RECT_BASE(13'h1FFE),
      .RECT_COUNT(1),
      .WORDS_PER_RECT(5)
   ) dut_b (
      .clk(clk),
      .reset(reset),
      .vblank_start(vblank_start),
      .cpu_wait(cpu_wait),
      .mem_rd_en(b_en),
      .mem_rd_addr(b_addr),
      .mem_rd_data(b_rdata),
      .rect_we(b_we),
      .rect_idx(b_idx),
      .rect_field(b_fld),
      .rect_data(b_data),
      .resume(b_res),
      .busy(b_busy)
`ifdef RECT_FETCH_SKIP_CNT_EN
      ,
      .skip_count(b_skip)
`endif
   );

   function automatic logic [15:0] mem_a(input logic [12:0] a);
      return 16'hA000 + {3'b000, a} - 16'h0100;
   endfunction

   function automatic logic [15:0] mem_b(input logic [12:0] a);
      return 16'hB000 + {3'b000, a};
   endfunction

   always_ff @(posedge clk) begin
      if (a_en) a_rdata <= mem_a(a_addr);
      if (b_en) b_rdata <= mem_b(b_addr);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        vb;
      logic        cw;
      logic        a_en;
      logic [12:0] a_addr;
      logic        a_we;
      logic [7:0]  a_idx;
      logic [2:0]  a_fld;
      logic [15:0] a_data;
      logic        a_res;
      logic        a_busy;
      logic        b_en;
      logic [12:0] b_addr;
      logic        b_we;
      logic [15:0] b_data;
      logic        b_res;
   } vec_t;

   vec_t tbl[14];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int na_en, na_we, na_res, nb_en, nb_we, nb_res, res_cyc, overlap;

      // cycle 0 = vblank pulse; A: 10 words, B: 5 words wrapping 1FFE
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 13'h000, 1'b0, 8'd0, 3'd0, 16'h0000,
                  1'b0, 1'b0, 1'b0, 13'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 13'h100, 1'b0, 8'd0, 3'd0, 16'h0000,
                  1'b0, 1'b1, 1'b1, 13'h1FFE, 1'b0, 16'h0000, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 13'h101, 1'b1, 8'd0, 3'd0, 16'hA000,
                  1'b0, 1'b1, 1'b1, 13'h1FFF, 1'b1, 16'hCFFE, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 13'h102, 1'b1, 8'd0, 3'd1, 16'hA001,
                  1'b0, 1'b1, 1'b1, 13'h0000, 1'b1, 16'hCFFF, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 13'h103, 1'b1, 8'd0, 3'd2, 16'hA002,
                  1'b0, 1'b1, 1'b1, 13'h0001, 1'b1, 16'hB000, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 13'h104, 1'b1, 8'd0, 3'd3, 16'hA003,
                  1'b0, 1'b1, 1'b1, 13'h0002, 1'b1, 16'hB001, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 13'h105, 1'b1, 8'd0, 3'd4, 16'hA004,
                  1'b0, 1'b1, 1'b0, 13'h0000, 1'b1, 16'hB002, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 13'h106, 1'b1, 8'd1, 3'd0, 16'hA005,
                  1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 16'h0000, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 13'h107, 1'b1, 8'd1, 3'd1, 16'hA006,
                  1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 13'h108, 1'b1, 8'd1, 3'd2, 16'hA007,
                  1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 13'h109, 1'b1, 8'd1, 3'd3, 16'hA008,
                  1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 13'h000, 1'b1, 8'd1, 3'd4, 16'hA009,
                  1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 13'h000, 1'b0, 8'd0, 3'd0, 16'h0000,
                  1'b1, 1'b0, 1'b0, 13'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 13'h000, 1'b0, 8'd0, 3'd0, 16'h0000,
                  1'b0, 1'b0, 1'b0, 13'h0000, 1'b0, 16'h0000, 1'b0};

      // reset state
      #1;
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst en", 32'(a_en), 0);
      chk("rst addr", 32'(a_addr), 0);
      chk("rst we", 32'(a_we), 0);
      chk("rst idx", 32'(a_idx), 0);
      chk("rst field", 32'(a_fld), 0);
      chk("rst data", 32'(a_data), 0);
      chk("rst resume", 32'(a_res), 0);
      chk("rst busy", 32'(a_busy), 0);
`ifdef RECT_FETCH_SKIP_CNT_EN
      chk("rst skip", 32'(a_skip), 0);
`endif
      next_cycle();
      reset = 1'b0;
      next_cycle();

      // basic fetch, cycle-accurate table
      for (int i = 0; i < 14; i++) begin
         vblank_start = tbl[i].vb;
         cpu_wait = tbl[i].cw;
         @(negedge clk);
         chk($sformatf("r%0d a_en", i), 32'(a_en), 32'(tbl[i].a_en));
         chk($sformatf("r%0d a_addr", i), 32'(a_addr), 32'(tbl[i].a_addr));
         chk($sformatf("r%0d a_we", i), 32'(a_we), 32'(tbl[i].a_we));
         chk($sformatf("r%0d a_idx", i), 32'(a_idx), 32'(tbl[i].a_idx));
         chk($sformatf("r%0d a_fld", i), 32'(a_fld), 32'(tbl[i].a_fld));
         chk($sformatf("r%0d a_data", i), 32'(a_data), 32'(tbl[i].a_data));
         chk($sformatf("r%0d a_res", i), 32'(a_res), 32'(tbl[i].a_res));
         chk($sformatf("r%0d a_busy", i), 32'(a_busy), 32'(tbl[i].a_busy));
         chk($sformatf("r%0d b_en", i), 32'(b_en), 32'(tbl[i].b_en));
         chk($sformatf("r%0d b_addr", i), 32'(b_addr), 32'(tbl[i].b_addr));
         chk($sformatf("r%0d b_we", i), 32'(b_we), 32'(tbl[i].b_we));
         chk($sformatf("r%0d b_data", i), 32'(b_data), 32'(tbl[i].b_data));
         chk($sformatf("r%0d b_res", i), 32'(b_res), 32'(tbl[i].b_res));
         next_cycle();
      end
      vblank_start = 1'b0;

      // overrun: CPU not waiting at vblank
      cpu_wait = 1'b0;
      na_en = 0; na_we = 0; na_res = 0; nb_en = 0; nb_res = 0;
      for (int c = 0; c < 16; c++) begin
         vblank_start = (c == 0);
         @(negedge clk);
         na_en += int'(a_en);
         na_we += int'(a_we);
         na_res += int'(a_res);
         nb_en += int'(b_en);
         nb_res += int'(b_res);
         next_cycle();
      end
      chk("ovr a_en", 32'(na_en), 0);
      chk("ovr a_we", 32'(na_we), 0);
      chk("ovr a_res", 32'(na_res), 0);
      chk("ovr b_en", 32'(nb_en), 0);
      chk("ovr b_res", 32'(nb_res), 0);
`ifdef RECT_FETCH_SKIP_CNT_EN
      chk("ovr a_skip", 32'(a_skip), 1);
      chk("ovr b_skip", 32'(b_skip), 1);
`endif

      // second vblank 3 cycles into the fetch is ignored
      cpu_wait = 1'b1;
      na_we = 0; na_res = 0; nb_we = 0; nb_res = 0;
      res_cyc = -1; overlap = 0;
      for (int c = 0; c < 30; c++) begin
         vblank_start = (c == 0) || (c == 3);
         @(negedge clk);
         na_we += int'(a_we);
         nb_we += int'(b_we);
         nb_res += int'(b_res);
         if (a_res) begin
            na_res++;
            res_cyc = c;
         end
         if (a_res && a_we) overlap++;
         next_cycle();
      end
      chk("busy a_writes", 32'(na_we), 10);
      chk("busy a_resumes", 32'(na_res), 1);
      chk("busy a_res_cycle", 32'(res_cyc), 12);
      chk("busy res_we_overlap", 32'(overlap), 0);
      chk("busy b_writes", 32'(nb_we), 5);
      chk("busy b_resumes", 32'(nb_res), 1);

      // CPU leaves WAIT during DRAIN: resume suppressed
      na_we = 0; na_res = 0;
      for (int c = 0; c < 16; c++) begin
         vblank_start = (c == 0);
         if (c == 11) cpu_wait = 1'b0;
         @(negedge clk);
         na_we += int'(a_we);
         na_res += int'(a_res);
         if (c == 12) chk("sup busy", 32'(a_busy), 0);
         next_cycle();
      end
      chk("sup a_writes", 32'(na_we), 10);
      chk("sup a_resumes", 32'(na_res), 0);
`ifdef RECT_FETCH_SKIP_CNT_EN
      chk("sup a_skip", 32'(a_skip), 2);
`endif

      // mid-fetch reset on READ cycle 4, then a clean restart
      cpu_wait = 1'b1;
      na_we = 0; na_res = 0;
      for (int c = 0; c < 26; c++) begin
         vblank_start = (c == 0);
         reset = (c == 4);
         @(negedge clk);
         if (c == 1) chk("mrst start addr", 32'(a_addr), 32'h100);
         if (c == 5) begin
            chk("mrst en", 32'(a_en), 0);
            chk("mrst addr", 32'(a_addr), 0);
            chk("mrst we", 32'(a_we), 0);
            chk("mrst idx", 32'(a_idx), 0);
            chk("mrst field", 32'(a_fld), 0);
            chk("mrst data", 32'(a_data), 0);
            chk("mrst busy", 32'(a_busy), 0);
            chk("mrst b_busy", 32'(b_busy), 0);
         end
         if (c >= 5) begin
            na_we += int'(a_we);
            na_res += int'(a_res);
         end
         next_cycle();
      end
      reset = 1'b0;
      chk("mrst late writes", 32'(na_we), 0);
      chk("mrst resumes", 32'(na_res), 0);
`ifdef RECT_FETCH_SKIP_CNT_EN
      chk("mrst a_skip", 32'(a_skip), 0);
`endif
      vblank_start = 1'b1;
      next_cycle();
      vblank_start = 1'b0;
      @(negedge clk);
      chk("restart en", 32'(a_en), 1);
      chk("restart addr", 32'(a_addr), 32'h100);
      next_cycle();
      @(negedge clk);
      chk("restart we", 32'(a_we), 1);
      chk("restart data", 32'(a_data), 32'hA000);
      for (int c = 0; c < 14; c++) next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rect_fetch.md
Name: rect_fetch

Overview:
- Frame-side counterpart of the CPU's WAIT/resume handshake.
- The CPU builds a rectangle table in data memory, then executes WAIT. At the start of vertical blank, this block reads the table through a read-only port of data memory and streams each word into the renderer's shadow registers. It then pulses resume so the CPU can build the next frame.
- It sits between the data memory read port B, the video timing generator and the CPU.

Parameters:
- DATA_WIDTH, 13, data memory address width.
- RECT_BASE, 13'h1000, data memory address of word 0 of the table.
- RECT_COUNT, 64, number of rectangles fetched per frame (1..256).
- WORDS_PER_RECT, 5, words per rectangle: x, y, w, h, color (1..8).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- vblank_start  in  1  one-cycle pulse at the first line of vertical blank.
- cpu_wait  in  1  CPU wait flag; high while the CPU is frozen on WAIT.
- mem_rd_en  out  1  data memory read enable.
- mem_rd_addr  out  DATA_WIDTH  data memory read address.
- mem_rd_data  in  16  read data; valid exactly 1 cycle after mem_rd_en (synchronous RAM).
- rect_we  out  1  shadow register write strobe.
- rect_idx  out  8  rectangle index of the current write.
- rect_field  out  3  field index within the rectangle (0..WORDS_PER_RECT-1).
- rect_data  out  16  word to write.
- resume  out  1  one-cycle pulse releasing the CPU.
- busy  out  1  high while the fetch is in progress (states READ and DRAIN).

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Counters are 0.
  - Reset mid-fetch aborts immediately, with no resume and no further writes.
- State machine:
  - IDLE
    - vblank_start=1 and cpu_wait=1 -> READ. Word counter i=0, rect_idx=0, rect_field=0.
    - vblank_start=1 and cpu_wait=0 -> frame skipped. Stay in IDLE, no memory access, no resume. This is the CPU overrunning its frame.
    - vblank_start is ignored in every state other than IDLE.
  - READ
    - Each cycle: mem_rd_en=1 and mem_rd_addr=RECT_BASE+i. The sum wraps modulo 2^DATA_WIDTH.
    - i increments by 1 each cycle.
    - After issuing the read for i=RECT_COUNT*WORDS_PER_RECT-1 -> DRAIN.
  - DRAIN
    - One cycle with mem_rd_en=0. This collects the last word -> RESUME.
  - RESUME
    - resume=1 for exactly one cycle -> IDLE.
- Write path (pipelined, 1-cycle lag):
  - In the cycle after each read issue: rect_we=1 and rect_data=mem_rd_data.
  - rect_idx and rect_field are the delayed copies of the issue-cycle indices.
  - Field/index counting:
    - rect_field increments per word.
    - When the field is WORDS_PER_RECT-1, the field resets to 0 and rect_idx increments.
    - No divider is used.
- Latency:
  - vblank_start to first mem_rd_en: 1 cycle.
  - vblank_start to resume: RECT_COUNT*WORDS_PER_RECT+2 cycles.
  - The block delivers exactly RECT_COUNT*WORDS_PER_RECT writes per fetched frame.
- Ordering and handshake:
  - resume is never asserted in the same cycle as rect_we.
  - resume is asserted only if cpu_wait is still 1 in the RESUME state. If cpu_wait is 0 there, resume is suppressed and the block returns to IDLE.
- Port ownership:
  - mem_rd_* must not be driven by anything else while busy=1.
  - The CPU performs no stores during a fetch because it is frozen.

Optional Feature:
- Macro RECT_FETCH_SKIP_CNT_EN.
- With the macro defined:
  - Adds output skip_count [15:0], reset to 0.
  - skip_count increments, saturating at 16'hFFFF, on each skipped frame (vblank_start=1 with cpu_wait=0 in IDLE).
  - Also increments on each suppressed resume.
- Without the macro: the port and the counter are absent, and behaviour is otherwise identical.

Test Plan:
- Basic fetch:
  - Setup: RECT_COUNT=2, WORDS_PER_RECT=5, RECT_BASE=13'h0100, memory[0x100+k]=16'hA000+k; cpu_wait=1, pulse vblank_start.
  - Reads: addresses 0x100..0x109 on 10 consecutive cycles.
  - Writes: 10 writes with (idx,field,data) running (0,0,A000)..(0,4,A004),(1,0,A005)..(1,4,A009).
  - Resume: a single pulse exactly 12 cycles after vblank_start.
- Overrun: cpu_wait=0 at vblank_start -> no mem_rd_en, no rect_we, no resume. With RECT_FETCH_SKIP_CNT_EN, skip_count goes 0->1.
- Vblank while busy: second vblank_start pulse 3 cycles into the fetch -> ignored; exactly 10 writes and one resume.
- Mid-fetch reset: reset asserted on cycle 4 of READ -> next cycle all outputs 0 and busy=0; no resume. A following vblank_start restarts from address 0x100.
- Address wrap: RECT_BASE=13'h1FFE, RECT_COUNT=1 -> addresses 1FFE,1FFF,0000,0001,0002.
- Suppressed resume: drop cpu_wait to 0 during DRAIN -> no resume pulse; with the macro, skip_count increments; back to IDLE.
